// File: rtl/pipeline_exec_ctrl.sv
// Execution controller for the five-stage pipeline: global stage enable, run/step modes,
// HALT detection with a fixed drain of older instructions, and a saturating enabled-cycle counter.
module pipeline_exec_ctrl #(
    parameter int CNT_W        = 32,
    parameter int DRAIN_CYCLES = 3
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             i_start,
    input  logic             i_mode,
    input  logic             i_step,
    input  logic             i_halt_id,
    output logic             o_pipe_en,
    output logic             o_fetch_stop,
    output logic             o_step_done,
    output logic             o_busy,
    output logic             o_halted,
    output logic [CNT_W-1:0] o_cycle_count
);

    typedef enum logic [2:0] {
        S_IDLE,
        S_RUN,
        S_WAIT_STEP,
        S_STEP,
        S_HALTED
    } state_e;

    localparam logic [3:0]       DRAIN_INIT = 4'(DRAIN_CYCLES);
    localparam logic [CNT_W-1:0] CNT_ONE    = CNT_W'(1);

    state_e           state_q, state_d;
    logic             drain_q, drain_d;
    logic [3:0]       drain_cnt_q, drain_cnt_d;
    logic             fetch_stop_q, fetch_stop_d;
    logic             pipe_en_q;
    logic             step_done_q;
    logic             busy_q;
    logic             halted_q;
    logic [CNT_W-1:0] cycle_count_q;

    logic halt_seen;
    logic drain_last;

    always_comb begin
        // NOTE: every signal assigned here gets a default first so no path leaves it
        // unassigned; otherwise synthesis infers a latch to hold the old value.
        state_d      = state_q;
        drain_d      = drain_q;
        drain_cnt_d  = drain_cnt_q;
        fetch_stop_d = fetch_stop_q;

        // The enable register doubles as "this cycle moves the pipeline".
        halt_seen  = pipe_en_q && !drain_q && i_halt_id;
        drain_last = pipe_en_q && drain_q && (drain_cnt_q == 4'd1);

        if (halt_seen) begin
            drain_d      = 1'b1;
            drain_cnt_d  = DRAIN_INIT;
            fetch_stop_d = 1'b1;
        end else if (pipe_en_q && drain_q) begin
            drain_cnt_d = drain_cnt_q - 4'd1;
        end

        case (state_q)
            S_IDLE: begin
                if (i_start) begin
                    state_d = i_mode ? S_WAIT_STEP : S_RUN;
                end
            end
            S_RUN: begin
                if (drain_last) begin
                    state_d = S_HALTED;
                end
            end
            S_WAIT_STEP: begin
                // A request landing in the step_done cycle is dropped, not queued.
                if (i_step && !step_done_q) begin
                    state_d = S_STEP;
                end
            end
            S_STEP: begin
                state_d = drain_last ? S_HALTED : S_WAIT_STEP;
            end
            S_HALTED: begin
                state_d = S_HALTED;
            end
            default: begin
                state_d = S_IDLE;
            end
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q       <= S_IDLE;
            drain_q       <= 1'b0;
            drain_cnt_q   <= 4'd0;
            fetch_stop_q  <= 1'b0;
            pipe_en_q     <= 1'b0;
            step_done_q   <= 1'b0;
            busy_q        <= 1'b0;
            halted_q      <= 1'b0;
            cycle_count_q <= '0;
        end else begin
            // NOTE: non-blocking assignments so every register samples pre-edge values,
            // independent of statement order within this block.
            state_q      <= state_d;
            drain_q      <= drain_d;
            drain_cnt_q  <= drain_cnt_d;
            fetch_stop_q <= fetch_stop_d;
            pipe_en_q    <= (state_d == S_RUN) || (state_d == S_STEP);
            step_done_q  <= (state_q == S_STEP);
            busy_q       <= (state_d != S_IDLE) && (state_d != S_HALTED);
            halted_q     <= (state_d == S_HALTED);
            if (pipe_en_q && (cycle_count_q != '1)) begin
                cycle_count_q <= cycle_count_q + CNT_ONE;
            end
        end
    end

    assign o_pipe_en     = pipe_en_q;
    assign o_fetch_stop  = fetch_stop_q;
    assign o_step_done   = step_done_q;
    assign o_busy        = busy_q;
    assign o_halted      = halted_q;
    assign o_cycle_count = cycle_count_q;

endmodule

// File: tb/tb_pipeline_exec_ctrl.sv
// Scoreboard bench for pipeline_exec_ctrl: per-cycle expectations derived from the
// controller's timing rules are queued with the stimulus and compared on the falling edge.
module tb_pipeline_exec_ctrl;

    logic clk     = 1'b0;
    logic rst     = 1'b0;
    logic start   = 1'b0;
    logic mode    = 1'b0;
    logic step    = 1'b0;
    logic halt    = 1'b0;
    logic start_s = 1'b0;

    logic        pipe_en, fetch_stop, step_done, busy, halted;
    logic [31:0] cycle_count;
    logic        s_pipe_en, s_fetch_stop, s_step_done, s_busy, s_halted;
    logic [3:0]  s_count;

    typedef struct packed {
        logic        en;
        logic        fs;
        logic        sd;
        logic        busy;
        logic        halted;
        logic [31:0] cnt;
    } exp_t;

    exp_t sb_q[$];
    int   n_checks = 0;
    int   n_pass   = 0;

    pipeline_exec_ctrl #(.CNT_W(32), .DRAIN_CYCLES(3)) dut (
        .clk           (clk),
        .rst           (rst),
        .i_start       (start),
        .i_mode        (mode),
        .i_step        (step),
        .i_halt_id     (halt),
        .o_pipe_en     (pipe_en),
        .o_fetch_stop  (fetch_stop),
        .o_step_done   (step_done),
        .o_busy        (busy),
        .o_halted      (halted),
        .o_cycle_count (cycle_count)
    );

    pipeline_exec_ctrl #(.CNT_W(4), .DRAIN_CYCLES(3)) dut_sat (
        .clk           (clk),
        .rst           (rst),
        .i_start       (start_s),
        .i_mode        (1'b0),
        .i_step        (1'b0),
        .i_halt_id     (1'b0),
        .o_pipe_en     (s_pipe_en),
        .o_fetch_stop  (s_fetch_stop),
        .o_step_done   (s_step_done),
        .o_busy        (s_busy),
        .o_halted      (s_halted),
        .o_cycle_count (s_count)
    );

    always #5 clk = ~clk;

    function automatic exp_t mk(logic en, logic fs, logic sd, logic bz, logic hl, int cnt);
        mk = {en, fs, sd, bz, hl, 32'(cnt)};
    endfunction

    function automatic int imin(int a, int b);
        return (a < b) ? a : b;
    endfunction

    task automatic apply_reset();
        @(negedge clk);
        rst     = 1'b1;
        start   = 1'b0;
        mode    = 1'b0;
        step    = 1'b0;
        halt    = 1'b0;
        start_s = 1'b0;
        sb_q.delete();
        @(negedge clk);
        rst = 1'b0;
    endtask

    task automatic test_reset();
        exp_t got;
        #2 rst = 1'b1;
        #1;
        got = {pipe_en, fetch_stop, step_done, busy, halted, cycle_count};
        n_checks++;
        if (got !== mk(0, 0, 0, 0, 0, 0))
            $display("FAIL reset_main: got %h, expected %h", got, mk(0, 0, 0, 0, 0, 0));
        else n_pass++;
        got = {s_pipe_en, s_fetch_stop, s_step_done, s_busy, s_halted, 28'd0, s_count};
        n_checks++;
        if (got !== mk(0, 0, 0, 0, 0, 0))
            $display("FAIL reset_sat: got %h, expected %h", got, mk(0, 0, 0, 0, 0, 0));
        else n_pass++;
        @(negedge clk);
        rst = 1'b0;
    endtask

    // Run mode, HALT in enabled cycle 10: enables 1..13, fetch_stop from 11, halted from 14.
    task automatic test_run_halt();
        exp_t got, e;
        int   n;
        logic en;
        apply_reset();
        sb_q.push_back(mk(0, 0, 0, 0, 0, 0));
        for (int c = 0; c <= 20; c++) begin
            got = {pipe_en, fetch_stop, step_done, busy, halted, cycle_count};
            n_checks++;
            if (sb_q.size() == 0) $display("FAIL run_halt cycle %0d: scoreboard empty", c);
            else begin
                e = sb_q.pop_front();
                if (got !== e)
                    $display("FAIL run_halt cycle %0d: got en,fs,sd,busy,halted=%b%b%b%b%b cnt=%0d, expected %b%b%b%b%b cnt=%0d",
                             c, got.en, got.fs, got.sd, got.busy, got.halted, got.cnt,
                             e.en, e.fs, e.sd, e.busy, e.halted, e.cnt);
                else n_pass++;
            end
            if (c < 20) begin
                start = (c == 0) || (c == 16);
                mode  = 1'b0;
                step  = (c == 5);
                halt  = (c == 10) || (c == 12);
                n     = c + 1;
                en    = (n >= 1) && (n <= 13);
                sb_q.push_back(mk(en, n >= 11, 0, en, n >= 14, imin(n - 1, 13)));
                @(negedge clk);
            end
        end
        start = 1'b0; step = 1'b0; halt = 1'b0;
        n_checks++;
        if (cycle_count !== 32'd13) $display("FAIL run_halt_final_count: got %0d, expected 13", cycle_count);
        else n_pass++;
    endtask

    // Step mode, five well-spaced steps: enables at 3,7,11,15,19 and done one cycle later each.
    task automatic test_step();
        exp_t got, e;
        int   n;
        apply_reset();
        sb_q.push_back(mk(0, 0, 0, 0, 0, 0));
        for (int c = 0; c <= 22; c++) begin
            got = {pipe_en, fetch_stop, step_done, busy, halted, cycle_count};
            n_checks++;
            if (sb_q.size() == 0) $display("FAIL step cycle %0d: scoreboard empty", c);
            else begin
                e = sb_q.pop_front();
                if (got !== e)
                    $display("FAIL step cycle %0d: got en,fs,sd,busy,halted=%b%b%b%b%b cnt=%0d, expected %b%b%b%b%b cnt=%0d",
                             c, got.en, got.fs, got.sd, got.busy, got.halted, got.cnt,
                             e.en, e.fs, e.sd, e.busy, e.halted, e.cnt);
                else n_pass++;
            end
            if (c < 22) begin
                start = (c == 0);
                mode  = 1'b1;
                step  = c inside {2, 6, 10, 14, 18};
                halt  = 1'b0;
                n     = c + 1;
                sb_q.push_back(mk(n inside {3, 7, 11, 15, 19}, 0, n inside {4, 8, 12, 16, 20}, 1, 0,
                                  int'(n > 3) + int'(n > 7) + int'(n > 11) + int'(n > 15) + int'(n > 19)));
                @(negedge clk);
            end
        end
        start = 1'b0; step = 1'b0; mode = 1'b0;
    endtask

    // Step mode, HALT on step 2: steps 3..5 drain, halted after step 5, sixth step ignored.
    task automatic test_step_halt();
        exp_t got, e;
        int   n;
        apply_reset();
        sb_q.push_back(mk(0, 0, 0, 0, 0, 0));
        for (int c = 0; c <= 26; c++) begin
            got = {pipe_en, fetch_stop, step_done, busy, halted, cycle_count};
            n_checks++;
            if (sb_q.size() == 0) $display("FAIL step_halt cycle %0d: scoreboard empty", c);
            else begin
                e = sb_q.pop_front();
                if (got !== e)
                    $display("FAIL step_halt cycle %0d: got en,fs,sd,busy,halted=%b%b%b%b%b cnt=%0d, expected %b%b%b%b%b cnt=%0d",
                             c, got.en, got.fs, got.sd, got.busy, got.halted, got.cnt,
                             e.en, e.fs, e.sd, e.busy, e.halted, e.cnt);
                else n_pass++;
            end
            if (c < 26) begin
                start = (c == 0);
                mode  = 1'b1;
                step  = c inside {2, 6, 10, 14, 18, 22};
                halt  = (c == 7) || (c == 11);
                n     = c + 1;
                sb_q.push_back(mk(n inside {3, 7, 11, 15, 19}, n >= 8, n inside {4, 8, 12, 16, 20},
                                  (n >= 1) && (n < 20), n >= 20,
                                  int'(n > 3) + int'(n > 7) + int'(n > 11) + int'(n > 15) + int'(n > 19)));
                @(negedge clk);
            end
        end
        start = 1'b0; step = 1'b0; halt = 1'b0; mode = 1'b0;
    endtask

    // Start+step together goes to WAIT_STEP only; steps during STEP or the done cycle are dropped.
    task automatic test_start_step_together();
        exp_t got, e;
        int   n;
        apply_reset();
        sb_q.push_back(mk(0, 0, 0, 0, 0, 0));
        for (int c = 0; c <= 9; c++) begin
            got = {pipe_en, fetch_stop, step_done, busy, halted, cycle_count};
            n_checks++;
            if (sb_q.size() == 0) $display("FAIL start_step cycle %0d: scoreboard empty", c);
            else begin
                e = sb_q.pop_front();
                if (got !== e)
                    $display("FAIL start_step cycle %0d: got en,fs,sd,busy,halted=%b%b%b%b%b cnt=%0d, expected %b%b%b%b%b cnt=%0d",
                             c, got.en, got.fs, got.sd, got.busy, got.halted, got.cnt,
                             e.en, e.fs, e.sd, e.busy, e.halted, e.cnt);
                else n_pass++;
            end
            if (c < 9) begin
                start = (c == 0);
                mode  = 1'b1;
                step  = c inside {0, 3, 4, 5};
                halt  = 1'b0;
                n     = c + 1;
                sb_q.push_back(mk(n == 4, 0, n == 5, 1, 0, int'(n > 4)));
                @(negedge clk);
            end
        end
        start = 1'b0; step = 1'b0; mode = 1'b0;
    endtask

    // Reset asserted mid-drain (drain counter at 2), then a fresh run counts from zero.
    task automatic test_reset_mid_drain();
        exp_t got, e;
        int   n;
        apply_reset();
        sb_q.push_back(mk(0, 0, 0, 0, 0, 0));
        for (int c = 0; c <= 5; c++) begin
            got = {pipe_en, fetch_stop, step_done, busy, halted, cycle_count};
            n_checks++;
            if (sb_q.size() == 0) $display("FAIL mid_drain cycle %0d: scoreboard empty", c);
            else begin
                e = sb_q.pop_front();
                if (got !== e)
                    $display("FAIL mid_drain cycle %0d: got en,fs,sd,busy,halted=%b%b%b%b%b cnt=%0d, expected %b%b%b%b%b cnt=%0d",
                             c, got.en, got.fs, got.sd, got.busy, got.halted, got.cnt,
                             e.en, e.fs, e.sd, e.busy, e.halted, e.cnt);
                else n_pass++;
            end
            if (c < 5) begin
                start = (c == 0);
                mode  = 1'b0;
                step  = 1'b0;
                halt  = (c == 3);
                n     = c + 1;
                sb_q.push_back(mk(n <= 6, n >= 4, 0, n <= 6, 0, n - 1));
                @(negedge clk);
            end
        end
        start = 1'b0; halt = 1'b0;
        #1 rst = 1'b1;
        #1;
        got = {pipe_en, fetch_stop, step_done, busy, halted, cycle_count};
        n_checks++;
        if (got !== mk(0, 0, 0, 0, 0, 0))
            $display("FAIL mid_drain_async_reset: got %h, expected %h", got, mk(0, 0, 0, 0, 0, 0));
        else n_pass++;
        @(negedge clk);
        rst = 1'b0;
        sb_q.delete();
        sb_q.push_back(mk(0, 0, 0, 0, 0, 0));
        for (int c = 0; c <= 6; c++) begin
            got = {pipe_en, fetch_stop, step_done, busy, halted, cycle_count};
            n_checks++;
            if (sb_q.size() == 0) $display("FAIL restart cycle %0d: scoreboard empty", c);
            else begin
                e = sb_q.pop_front();
                if (got !== e)
                    $display("FAIL restart cycle %0d: got en,fs,sd,busy,halted=%b%b%b%b%b cnt=%0d, expected %b%b%b%b%b cnt=%0d",
                             c, got.en, got.fs, got.sd, got.busy, got.halted, got.cnt,
                             e.en, e.fs, e.sd, e.busy, e.halted, e.cnt);
                else n_pass++;
            end
            if (c < 6) begin
                start = (c == 0);
                n     = c + 1;
                sb_q.push_back(mk(1, 0, 0, 1, 0, n - 1));
                @(negedge clk);
            end
        end
        start = 1'b0;
    endtask

    // Four-bit counter in run mode for 20+ cycles saturates at 4'hF and holds.
    task automatic test_saturate();
        exp_t got, e;
        int   n;
        apply_reset();
        sb_q.push_back(mk(0, 0, 0, 0, 0, 0));
        for (int c = 0; c <= 21; c++) begin
            got = {s_pipe_en, s_fetch_stop, s_step_done, s_busy, s_halted, 28'd0, s_count};
            n_checks++;
            if (sb_q.size() == 0) $display("FAIL saturate cycle %0d: scoreboard empty", c);
            else begin
                e = sb_q.pop_front();
                if (got !== e)
                    $display("FAIL saturate cycle %0d: got en,busy=%b%b cnt=%0d, expected %b%b cnt=%0d",
                             c, got.en, got.busy, got.cnt, e.en, e.busy, e.cnt);
                else n_pass++;
            end
            if (c < 21) begin
                start_s = (c == 0);
                n       = c + 1;
                sb_q.push_back(mk(1, 0, 0, 1, 0, imin(n - 1, 15)));
                @(negedge clk);
            end
        end
        start_s = 1'b0;
    endtask

    initial begin
        test_reset();
        test_run_halt();
        test_step();
        test_step_halt();
        test_start_step_together();
        test_reset_mid_drain();
        test_saturate();
        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation exceeded time limit, passed %0d of %0d", n_pass, n_checks);
        $fatal(1, "watchdog");
    end

endmodule
